// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the traffic light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    StNsGreen  = 3'd0,
    StNsYellow = 3'd1,
    StRedA     = 3'd2,
    StEwGreen  = 3'd3,
    StEwYellow = 3'd4,
    StRedB     = 3'd5
  } tl_state_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  function automatic tl_state_t tl_next(input tl_state_t s);
    unique case (s)
      StNsGreen:  tl_next = StNsYellow;
      StNsYellow: tl_next = StRedA;
      StRedA:     tl_next = StEwGreen;
      StEwGreen:  tl_next = StEwYellow;
      StEwYellow: tl_next = StRedB;
      default:    tl_next = StNsGreen;
    endcase
  endfunction

  function automatic logic [2:0] ns_head(input tl_state_t s);
    unique case (s)
      StNsGreen:  ns_head = LT_GRN;
      StNsYellow: ns_head = LT_YEL;
      default:    ns_head = LT_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_head(input tl_state_t s);
    unique case (s)
      StEwGreen:  ew_head = LT_GRN;
      StEwYellow: ew_head = LT_YEL;
      default:    ew_head = LT_RED;
    endcase
  endfunction

  function automatic logic is_green(input tl_state_t s);
    return (s == StNsGreen) || (s == StEwGreen);
  endfunction

endpackage

// File: rtl/tl_countdown.sv
// Loadable seconds down-counter; never counts below 1, done marks the final tick.
module tl_countdown #(
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned RST_VAL   = 2,
  parameter int unsigned FORCE_VAL = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  input  logic             force_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] One    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RstC   = CNT_W'(RST_VAL);
  localparam logic [CNT_W-1:0] ForceC = CNT_W'(FORCE_VAL);

  logic [CNT_W-1:0] count_q, count_d;

  // Force beats a simultaneous tick: the tick is swallowed by the shortening.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (force_i) begin
      count_d = ForceC;
    end else if (tick_i && (count_q > One)) begin
      count_d = count_q - One;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= RstC;
    else         count_q <= count_d;
  end

  assign count_o = count_q;
  assign done_o  = tick_i && (count_q == One);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer with per-phase countdown.
// Define TLC_PED_REQ_EN to enable pedestrian-request green shortening.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_S  = 30,
  parameter int unsigned YELLOW_S = 3,
  parameter int unsigned ALLRED_S = 2,
  parameter int unsigned SHORT_S  = 5,
  parameter int unsigned CNT_W    = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tick_1hz,
  input  logic             ped_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] remain,
  output logic             ped_ack
);

  localparam logic [CNT_W-1:0] ShortC = CNT_W'(SHORT_S);

  tl_state_t        state_q, state_d;
  logic [2:0]       ns_q, ew_q;
  logic             load, done, force_short;
  logic [CNT_W-1:0] load_val;

  function automatic logic [CNT_W-1:0] duration(input tl_state_t s);
    unique case (s)
      StNsGreen, StEwGreen:   duration = CNT_W'(GREEN_S);
      StNsYellow, StEwYellow: duration = CNT_W'(YELLOW_S);
      default:                duration = CNT_W'(ALLRED_S);
    endcase
  endfunction

  tl_countdown #(
    .CNT_W    (CNT_W),
    .RST_VAL  (ALLRED_S),
    .FORCE_VAL(SHORT_S)
  ) u_countdown (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .load_i    (load),
    .load_val_i(load_val),
    .tick_i    (tick_1hz),
    .force_i   (force_short),
    .count_o   (remain),
    .done_o    (done)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = remain;
    if (done) begin
      state_d  = tl_next(state_q);
      load     = 1'b1;
      load_val = duration(state_d);
    end
  end

  // Heads are decoded from the next state so they land in the same register stage.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StRedB;
      ns_q    <= LT_RED;
      ew_q    <= LT_RED;
    end else begin
      state_q <= state_d;
      ns_q    <= ns_head(state_d);
      ew_q    <= ew_head(state_d);
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;

`ifdef TLC_PED_REQ_EN
  logic ped_pending_q, ped_pending_d;
  logic ped_ack_q, ped_ack_d;
  logic pend_now, service;

  // A request arriving this cycle is serviced as if it were already pending.
  always_comb begin
    pend_now      = ped_pending_q | ped_req;
    service       = pend_now && is_green(state_q);
    force_short   = service && (remain > ShortC);
    ped_pending_d = service ? 1'b0 : pend_now;
    ped_ack_d     = service;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      ped_pending_q <= ped_pending_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  assign ped_ack = ped_ack_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign force_short    = 1'b0;
  assign ped_ack        = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl; pedestrian expectations follow TLC_PED_REQ_EN.
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

`ifdef TLC_PED_REQ_EN
  localparam bit PedEn = 1'b1;
`else
  localparam bit PedEn = 1'b0;
`endif

  typedef struct {
    logic       tick;
    logic       req;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [3:0] rem;
  } vec_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic [3:0] remain;
  logic       ped_ack;

  int  vectors = 0;
  int  miscompares = 0;
  bit  safety_bad = 1'b0;
  vec_t tbl[$];

  traffic_light_ctrl #(
    .GREEN_S (5),
    .YELLOW_S(2),
    .ALLRED_S(1),
    .SHORT_S (2),
    .CNT_W   (4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .tick_1hz (tick_1hz),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .remain   (remain),
    .ped_ack  (ped_ack)
  );

  always #5 sys_clk = ~sys_clk;

  // Both heads must never leave red together; heads must stay one-hot.
  always @(negedge sys_clk) begin
    if ((ns_light != LT_RED && ew_light != LT_RED) || !$onehot(ns_light) || !$onehot(ew_light))
      safety_bad = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic r);
    @(negedge sys_clk);
    tick_1hz = t;
    ped_req  = r;
    @(posedge sys_clk);
    #1;
    tick_1hz = 1'b0;
    ped_req  = 1'b0;
  endtask

  task automatic add(input logic t, input logic [2:0] ns, input logic [2:0] ew,
                     input logic [3:0] rem);
    vec_t v;
    v.tick = t; v.req = 1'b0; v.ns = ns; v.ew = ew; v.rem = rem;
    tbl.push_back(v);
  endtask

  task automatic chk_state(input string name, input logic [2:0] ns, input logic [2:0] ew,
                           input int rem, input int ack);
    chk({name, ".ns"}, int'(ns_light), int'(ns));
    chk({name, ".ew"}, int'(ew_light), int'(ew));
    chk({name, ".rem"}, int'(remain), rem);
    chk({name, ".ack"}, int'(ped_ack), ack);
  endtask

  initial begin
    // Full cycle from reset, with a couple of idle (no-tick) holds mixed in.
    add(1, LT_GRN, LT_RED, 5); add(1, LT_GRN, LT_RED, 4); add(0, LT_GRN, LT_RED, 4);
    add(1, LT_GRN, LT_RED, 3); add(1, LT_GRN, LT_RED, 2); add(1, LT_GRN, LT_RED, 1);
    add(1, LT_YEL, LT_RED, 2); add(1, LT_YEL, LT_RED, 1); add(1, LT_RED, LT_RED, 1);
    add(1, LT_RED, LT_GRN, 5); add(0, LT_RED, LT_GRN, 5); add(1, LT_RED, LT_GRN, 4);
    add(1, LT_RED, LT_GRN, 3); add(1, LT_RED, LT_GRN, 2); add(1, LT_RED, LT_GRN, 1);
    add(1, LT_RED, LT_YEL, 2); add(1, LT_RED, LT_YEL, 1); add(1, LT_RED, LT_RED, 1);

    repeat (3) @(posedge sys_clk);
    #1;
    chk_state("reset", LT_RED, LT_RED, 1, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].tick, tbl[i].req);
      chk($sformatf("vec%0d.ns", i), int'(ns_light), int'(tbl[i].ns));
      chk($sformatf("vec%0d.ew", i), int'(ew_light), int'(tbl[i].ew));
      chk($sformatf("vec%0d.rem", i), int'(remain), int'(tbl[i].rem));
      chk($sformatf("vec%0d.ack", i), int'(ped_ack), 0);
    end

    // Request in NS_GREEN at remain=4.
    cyc(1, 0);
    cyc(1, 0);
    chk_state("ns_pre", LT_GRN, LT_RED, 4, 0);
    cyc(0, 1);
    chk_state("ns_short", LT_GRN, LT_RED, PedEn ? 2 : 4, PedEn ? 1 : 0);
    cyc(0, 0);
    chk_state("ns_ack_once", LT_GRN, LT_RED, PedEn ? 2 : 4, 0);
    repeat (PedEn ? 2 : 4) cyc(1, 0);
    chk_state("ns_to_yel", LT_YEL, LT_RED, 2, 0);

    // Request during yellow is held until EW_GREEN entry.
    cyc(0, 1);
    chk_state("yel_hold", LT_YEL, LT_RED, 2, 0);
    cyc(1, 0);
    chk_state("yel_1", LT_YEL, LT_RED, 1, 0);
    cyc(1, 0);
    chk_state("red_a", LT_RED, LT_RED, 1, 0);
    cyc(1, 0);
    chk_state("ew_entry", LT_RED, LT_GRN, 5, 0);
    cyc(0, 0);
    chk_state("ew_service", LT_RED, LT_GRN, PedEn ? 2 : 5, PedEn ? 1 : 0);
    cyc(0, 0);
    chk_state("ew_ack_once", LT_RED, LT_GRN, PedEn ? 2 : 5, 0);

    // Asynchronous reset mid-EW_GREEN, between clock edges.
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_state("async_rst", LT_RED, LT_RED, 1, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cyc(1, 0);
    chk_state("post_rst", LT_GRN, LT_RED, 5, 0);
    repeat (8) cyc(1, 0);
    chk_state("ew_again", LT_RED, LT_GRN, 5, 0);

    // Request and tick in the same cycle: shortening wins.
    cyc(1, 1);
    chk_state("tick_req", LT_RED, LT_GRN, PedEn ? 2 : 4, PedEn ? 1 : 0);
    cyc(0, 0);
    chk_state("tick_req_once", LT_RED, LT_GRN, PedEn ? 2 : 4, 0);
    repeat (PedEn ? 2 : 4) cyc(1, 0);
    chk_state("ew_to_yel", LT_RED, LT_YEL, 2, 0);

    chk("safety", int'(safety_bad), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Sequences a two-road (north-south / east-west) intersection through green, yellow and all-red phases. Each phase has a configurable duration in seconds. Time advances on a one-cycle 1 Hz enable pulse produced by the divider, so the controller runs entirely in the `sys_clk` domain. The block drives both light heads, a seconds-remaining value for the countdown display, and, optionally, a pedestrian-request shortening of the current green.

## Interface
- `GREEN_S`, default 30: green duration in seconds, ≥1.
- `YELLOW_S`, default 3: yellow duration in seconds, ≥1.
- `ALLRED_S`, default 2: all-red clearance duration in seconds, ≥1.
- `SHORT_S`, default 5: green remainder after a pedestrian request, 1 ≤ `SHORT_S` ≤ `GREEN_S`.
- `CNT_W`, default 6: width of the countdown. Every duration must fit in it.
- `sys_clk` in 1: system clock, 100 MHz.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `tick_1hz` in 1: single-cycle enable, synchronous to `sys_clk`, one pulse per second.
- `ped_req` in 1: pedestrian button, already synchronised and debounced. A high level in any cycle counts as a request.
- `ns_light` out 3: NS head as {red, yellow, green}, one-hot.
- `ew_light` out 3: EW head as {red, yellow, green}, one-hot.
- `remain` out `CNT_W`: seconds left in the current phase, from the duration down to 1.
- `ped_ack` out 1: one-cycle pulse when a pending request is consumed.

## Operation
- States, in fixed cyclic order: `NS_GREEN` → `NS_YELLOW` → `RED_A` → `EW_GREEN` → `EW_YELLOW` → `RED_B` → `NS_GREEN`.
- Light outputs per state:
  - `NS_GREEN`: NS=001, EW=100.
  - `NS_YELLOW`: NS=010, EW=100.
  - `EW_GREEN`: NS=100, EW=001.
  - `EW_YELLOW`: NS=100, EW=010.
  - `RED_A` / `RED_B`: NS=100, EW=100.
- Countdown behaviour:
  - On entry to a state, `remain` loads that state's duration.
  - Each `tick_1hz` with `remain`>1 decrements `remain`.
  - A `tick_1hz` with `remain`==1 advances the state and loads the next duration.
  - Each state therefore lasts exactly its duration in ticks. `remain` is never 0 after reset.
- Width rule: `remain` is unsigned `CNT_W`. No arithmetic wraps, because decrement only happens when `remain`>1.
- Safety invariant: at no time may both heads show anything other than red. The bench asserts this every cycle.
- Pedestrian request (under the macro):
  - `ped_req` sets a `ped_pending` flag.
  - When `ped_pending` is set and the state is `NS_GREEN` or `EW_GREEN`:
    - if `remain`>`SHORT_S`, `remain` is forced to `SHORT_S`;
    - otherwise `remain` is unchanged.
    - In both cases `ped_pending` clears and `ped_ack` pulses, one cycle after the condition is seen.
  - In yellow or red states, `ped_pending` is held until the next green entry. It is then serviced on the first green cycle.
  - Additional requests while pending are absorbed: one ack per pending period.
- Simultaneous events:
  - Shortening and `tick_1hz` in the same cycle: the shortening wins, `remain`=`SHORT_S`, and the tick is consumed.
  - `ped_req` in the same cycle as an ack: the request re-sets `ped_pending`.

## Timing
- All outputs are registered. Lights and `remain` change in the cycle after the deciding `tick_1hz`, or after the pending condition for a shortening.
- Reset values, applied asynchronously on `sys_rst_n`=0:
  - state `RED_B`;
  - `remain`=`ALLRED_S`;
  - `ns_light`=`ew_light`=100;
  - `ped_ack`=0;
  - `ped_pending`=0.
- Reset mid-phase aborts immediately to the reset values. After release, the first `NS_GREEN` begins after `ALLRED_S` ticks.
- Back-to-back `tick_1hz` cycles are legal, and each one counts as a second.

## Configuration
- Macro `TLC_PED_REQ_EN`:
  - Defined: pedestrian logic as described above.
  - Undefined: `ped_req` is ignored, `ped_pending` is absent, `ped_ack` is tied to 0, and the ports remain present.
- The phase sequence is identical in both builds.

## Structure
- Shared package `traffic_pkg`:
  - state enum `tl_state_t`;
  - light encodings `LT_RED`=3'b100, `LT_YEL`=3'b010, `LT_GRN`=3'b001.
- Sub-module `tl_countdown`: a loadable down-counter with inputs load, load value, tick and force, and outputs count and done (count==1 and tick). The FSM in `traffic_light_ctrl` instantiates it once.

## Test plan
Bench parameters: `GREEN_S`=5, `YELLOW_S`=2, `ALLRED_S`=1, `SHORT_S`=2, `CNT_W`=4.
- Reset, then 16 ticks → states `RED_B`(1), `NS_GREEN`(5..1), `NS_YELLOW`(2,1), `RED_A`(1), `EW_GREEN`(5..1), `EW_YELLOW`(2,1), `RED_B`(1), matching the light codes in order.
- `ped_req` pulse in `NS_GREEN` at `remain`=4 → the next cycle shows `remain`=2 and `ped_ack`=1 for one cycle. After 2 ticks the state is `NS_YELLOW`.
- `ped_req` during `NS_YELLOW` → no ack until `EW_GREEN` entry. In the first `EW_GREEN` cycle `remain` is 5; the next cycle shows `remain`=2 and `ped_ack`=1.
- `ped_req` and `tick_1hz` in the same cycle during `EW_GREEN`, `remain`=5 → `remain`=2 (not 4), with one ack.
- Assert `sys_rst_n`=0 asynchronously mid-`EW_GREEN` → same cycle, both heads show 100 and `remain`=1.
- Build without `TLC_PED_REQ_EN` and repeat the scenario with a `ped_req` pulse in `NS_GREEN` → no shortening and `ped_ack` stays 0.
